// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external alu_64 between two requesters.
// One operation is in flight at a time: IDLE -> EXEC -> RESP.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req0_ctrl,
  input  logic [1:0]       req1_ctrl,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_ctrl;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             w_gnt;
  logic             w_accept;

  // On a tie the requester not served last wins
  always_comb begin
    w_next   = r_state;
    w_gnt    = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_gnt    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
        w_accept = req0_valid || req1_valid;
        if (w_accept) w_next = S_EXEC;
      end
      S_EXEC:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_ctrl   <= 2'b00;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= w_gnt ? req1_a : req0_a;
        r_b    <= w_gnt ? req1_b : req0_b;
        r_ctrl <= w_gnt ? req1_ctrl : req0_ctrl;
        r_id   <= w_gnt;
      end
      // Logical ops cannot overflow
      if (r_state == S_EXEC) begin
        r_result <= alu_sum;
        r_ovf    <= alu_ovf & ~r_ctrl[1];
      end
      if (r_state == S_RESP) r_last <= r_id;
    end
  end

  assign req0_ready  = rst_n & w_accept & ~w_gnt;
  assign req1_ready  = rst_n & w_accept & w_gnt;
  assign resp0_valid = (r_state == S_RESP) & ~r_id;
  assign resp1_valid = (r_state == S_RESP) & r_id;
  assign resp_result = r_result;
  assign resp_ovf    = r_ovf;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_ctrl    = r_ctrl;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural alu_64 and
// a transaction-level round-robin reference model.
module tb_alu_arbiter;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         req0_valid;
  logic         req1_valid;
  logic         req0_ready;
  logic         req1_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [1:0]   req0_ctrl;
  logic [1:0]   req1_ctrl;
  logic         resp0_valid;
  logic         resp1_valid;
  logic [W-1:0] resp_result;
  logic         resp_ovf;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_ctrl;
  logic [W-1:0] alu_sum;
  logic         alu_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit         m_last;
  logic [W-1:0] m_res;
  bit         m_ovf;
  bit         winners[$];

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .req0_a(req0_a),
    .req0_b(req0_b),
    .req1_a(req1_a),
    .req1_b(req1_b),
    .req0_ctrl(req0_ctrl),
    .req1_ctrl(req1_ctrl),
    .resp0_valid(resp0_valid),
    .resp1_valid(resp1_valid),
    .resp_result(resp_result),
    .resp_ovf(resp_ovf),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_ctrl(alu_ctrl),
    .alu_sum(alu_sum),
    .alu_ovf(alu_ovf),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns {signed overflow, result}
  function automatic logic [W:0] ref_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [1:0]   c
  );
    logic signed [W+1:0] wide;
    logic [W:0]          r;
    r = '0;
    case (c)
      2'b00: wide = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
      2'b01: wide = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
      default: wide = '0;
    endcase
    if (c[1]) begin
      r[W-1:0] = (c == 2'b10) ? (a & b) : (a ^ b);
    end else begin
      r[W-1:0] = wide[W-1:0];
      r[W] = (wide > $signed(66'sh0_7FFF_FFFF_FFFF_FFFF)) ||
             (wide < -$signed(66'sh0_8000_0000_0000_0000));
    end
    return r;
  endfunction

  // External ALU: raw ovf is junk (1) for logical ops
  always_comb begin
    {alu_ovf, alu_sum} = ref_op(alu_a, alu_b, alu_ctrl);
    if (alu_ctrl[1]) alu_ovf = 1'b1;
  end

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return '1;
      3: return '0;
      default: return rnd64();
    endcase
  endfunction

  task automatic chk(
    input string        tag,
    input logic [W-1:0] obs,
    input logic [W-1:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet_outs(input string tag);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_resp0"}, resp0_valid, 0);
    chk({tag, "_resp1"}, resp1_valid, 0);
  endtask

  // Called shortly after a rising edge; returns one edge past RESP
  task automatic op(
    input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
    input logic [1:0] c0,
    input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
    input logic [1:0] c1
  );
    bit           w;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [1:0]   ec;
    logic [W:0]   r;
    w  = (v0 && v1) ? !m_last : v1;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    ec = w ? c1 : c0;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    @(negedge clk);
    chk("acc_ready0", req0_ready, !w);
    chk("acc_ready1", req1_ready, w);
    chk("acc_busy", busy, 0);
    chk("acc_resp0", resp0_valid, 0);
    chk("acc_resp1", resp1_valid, 0);
    chk("hold_result", resp_result, m_res);
    chk("hold_ovf", resp_ovf, m_ovf);
    @(posedge clk); #1;
    req0_a = rnd64(); req0_b = rnd64(); req0_ctrl = 2'($urandom);
    req1_a = rnd64(); req1_b = rnd64(); req1_ctrl = 2'($urandom);
    @(negedge clk);
    chk_quiet_outs("exec");
    chk("exec_busy", busy, 1);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_ctrl", alu_ctrl, ec);
    @(posedge clk); #1;
    @(negedge clk);
    r = ref_op(ea, eb, ec);
    m_res = r[W-1:0];
    m_ovf = r[W];
    chk("resp_valid0", resp0_valid, !w);
    chk("resp_valid1", resp1_valid, w);
    chk("resp_result", resp_result, m_res);
    chk("resp_ovf", resp_ovf, m_ovf);
    chk("resp_busy", busy, 1);
    chk("resp_ready0", req0_ready, 0);
    chk("resp_ready1", req1_ready, 0);
    @(posedge clk); #1;
    m_last = w;
    winners.push_back(w);
  endtask

  task automatic idle_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk_quiet_outs("idle");
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  // Valids held high to confirm ready is suppressed in reset
  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk_quiet_outs("rst");
    chk("rst_busy", busy, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_ovf", resp_ovf, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = 1'b1;
    m_res = '0;
    m_ovf = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    do_reset();

    op(1, 64'd5, 64'd7, 2'b00, 0, rnd64(), rnd64(), 2'b00);
    chk("add_5_7", resp_result, 64'd12);
    chk("add_5_7_ovf", resp_ovf, 0);

    op(0, rnd64(), rnd64(), 2'b00,
       1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00);
    chk("add_ovf_res", resp_result, 64'h8000_0000_0000_0000);
    chk("add_ovf_flag", resp_ovf, 1);

    do_reset();
    op(1, 64'd9, 64'd3, 2'b01, 1, 64'h2B7, 64'h223, 2'b10);
    chk("tie_first_res", resp_result, 64'd6);
    op(0, 64'd9, 64'd3, 2'b01, 1, 64'h2B7, 64'h223, 2'b10);
    chk("tie_second_res", resp_result, 64'h223);
    chk("tie_second_ovf", resp_ovf, 0);

    do_reset();
    winners.delete();
    for (int i = 0; i < 6; i++)
      op(1, pick(), pick(), 2'($urandom),
         1, pick(), pick(), 2'($urandom));
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order_%0d", i), winners[i], (i % 2));

    for (int i = 0; i < 30; i++) begin
      int unsigned r;
      r = $urandom_range(0, 3);
      if (r == 0) idle_cycle();
      else op(r[0], pick(), pick(), 2'($urandom),
              r[1], pick(), pick(), 2'($urandom));
    end

    req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd1;
    req0_ctrl = 2'b00; req1_valid = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("abort_in_exec", busy, 1);
    do_reset();
    idle_cycle();
    idle_cycle();
    op(1, 64'h55, 64'h0F, 2'b11, 0, rnd64(), rnd64(), 2'b00);
    chk("post_abort_xor", resp_result, 64'h5A);
    chk("post_abort_ovf", resp_ovf, 0);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; must match the shared alu_64 instance.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester i has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation of requester i accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  signed operands.
REQ-007 SHALL have ports req0_ctrl / req1_ctrl  input  2  op code: 00 add, 01 a-b, 10 and, 11 xor.
REQ-008 SHALL have ports resp0_valid / resp1_valid  output  1  one-cycle result strobe for requester i.
REQ-009 SHALL have port resp_result  output  WIDTH  registered ALU result.
REQ-010 SHALL have port resp_ovf  output  1  registered overflow flag.
REQ-011 SHALL have ports alu_a, alu_b  output  WIDTH  and alu_ctrl  output  2  driving the external shared alu_64.
REQ-012 SHALL have ports alu_sum  input  WIDTH  and alu_ovf  input  1  from the shared alu_64.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; transitions IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-015 SHALL assert reqi_ready combinationally only in IDLE, only for the granted requester, at most one ready per cycle.
REQ-016 SHALL grant in IDLE: if only one valid, that one; if both valid, the requester not served last (round-robin pointer `last`).
REQ-017 SHALL on accept latch the granted a, b, ctrl and requester id into operand registers; requester inputs are don't-care afterwards.
REQ-018 SHALL drive alu_a/alu_b/alu_ctrl from operand registers at all times (never directly from request inputs).
REQ-019 SHALL at the EXEC->RESP edge capture alu_sum into resp_result and alu_ovf into resp_ovf; resp_ovf forced 0 when ctrl is 10 or 11.
REQ-020 SHALL assert resp_valid of the latched requester for exactly the RESP cycle; no backpressure; the other resp_valid stays 0.
REQ-021 SHALL hold resp_result/resp_ovf stable from capture until the next capture.
REQ-022 SHALL update `last` to the served requester on the RESP->IDLE edge.
REQ-023 SHALL give latency: accept at edge N, resp_valid high in cycle N+1..N+2 window i.e. during the cycle after EXEC (2 cycles after accept); throughput one op per 3 cycles.
REQ-024 SHALL ignore reqi_valid outside IDLE (ready low); a requester keeping valid high is accepted on the next IDLE cycle per REQ-016.
REQ-025 SHALL never starve: with both valid continuously, grants alternate 0,1,0,1.

Reset
REQ-026 SHALL on rst_n low immediately force state IDLE, operand/result registers 0, alu_ctrl 00, all ready/resp_valid 0, resp_ovf 0, busy 0, `last`=1 (req0 wins first tie).
REQ-027 SHALL on reset during EXEC or RESP abort the operation with no resp_valid issued after release.
REQ-028 SHALL accept a request in the first IDLE cycle after rst_n deasserts.

Verification
REQ-029 SHALL cover: req0 a=5,b=7,ctrl=00 alone -> req0_ready 1 cycle, resp0_valid 2 cycles later, resp_result=12, resp_ovf=0, resp1_valid never.
REQ-030 SHALL cover: req1 a=0x7FFF_FFFF_FFFF_FFFF,b=1,ctrl=00 -> resp1_valid, resp_result=0x8000_0000_0000_0000, resp_ovf=1.
REQ-031 SHALL cover: both valid after reset, req0 a=9,b=3,ctrl=01; req1 a=0x2B7,b=0x223,ctrl=10 -> resp0 first result 6, then resp1 result 0x223, resp_ovf=0; 6 cycles total.
REQ-032 SHALL cover: both held valid for 6 ops -> grant order 0,1,0,1,0,1; busy low only one cycle between ops.
REQ-033 SHALL cover: rst_n pulsed low mid-EXEC of a=1,b=1 -> no resp_valid, outputs 0 asynchronously, next req0 a=0x55,b=0x0F,ctrl=11 returns 0x5A.
